// File: rtl/img_arb_pkg.sv
// Shared types and default geometry for the image RAM arbiter.
// Optional build macro used by the top: IMG_ARB_VBLANK_WR_EN.
package img_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VGA,
        OWN_CPU
    } owner_t;

    localparam int IMG_W      = 100;
    localparam int IMG_H      = 100;
    localparam int IMG_ADDR_W = 14;

endpackage

// File: rtl/image_mem_arbiter_if.sv
// CPU/loader req/gnt bus into the image RAM arbiter.
// master = requester side, slave = arbiter side.
interface image_mem_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
);

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata
    );

endinterface

// File: rtl/img_addr_gen.sv
// Image-window hit detect and multiplier-free read address
// (running row base plus column offset).
module img_addr_gen #(
    parameter int WIN_X  = 0,
    parameter int WIN_Y  = 0,
    parameter int WIN_W  = 100,
    parameter int WIN_H  = 100,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_en,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    output logic              vga_fetch,
    output logic [ADDR_W-1:0] vga_addr
);

    localparam logic [10:0] X_LO = 11'(WIN_X);
    localparam logic [10:0] Y_LO = 11'(WIN_Y);
    localparam logic [10:0] W_SZ = 11'(WIN_W);
    localparam logic [10:0] H_SZ = 11'(WIN_H);

    logic [10:0]       col_off;
    logic [10:0]       row_off;
    logic              in_col;
    logic              in_row;
    logic              last_col;
    logic [ADDR_W-1:0] row_base;

    // Offsets wrap to large values left/above the window, so one
    // unsigned compare covers both bounds.
    assign col_off  = {1'b0, x} - X_LO;
    assign row_off  = {1'b0, y} - Y_LO;
    assign in_col   = col_off < W_SZ;
    assign in_row   = row_off < H_SZ;
    assign last_col = col_off == (W_SZ - 11'd1);

    assign vga_fetch = pix_en && in_col && in_row;
    assign vga_addr  = row_base + ADDR_W'(col_off);

    always_ff @(posedge clk) begin
        if (rst) begin
            row_base <= '0;
        end else if (pix_en && !in_row) begin
            row_base <= '0;
        end else if (vga_fetch && last_col) begin
            row_base <= row_base + ADDR_W'(WIN_W);
        end
    end

endmodule

// File: rtl/image_mem_arbiter.sv
// Single-port image RAM shared by VGA fetch (absolute priority) and CPU.
// Build macro IMG_ARB_VBLANK_WR_EN: CPU writes only during vertical blanking.
module image_mem_arbiter
    import img_arb_pkg::*;
#(
    parameter int WIN_X    = 0,
    parameter int WIN_Y    = 0,
    parameter int WIN_W    = IMG_W,
    parameter int WIN_H    = IMG_H,
    parameter int ADDR_W   = IMG_ADDR_W,
    parameter int DATA_W   = 8,
    parameter int V_ACTIVE = 480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_en,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_hit,
    image_mem_arbiter_if.slave cpu,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              vga_fetch;
    logic [ADDR_W-1:0] vga_addr;
    logic              wr_ok;
    logic              gnt;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic              miss_q;
    owner_t            owner_q;
    owner_t            owner_d;

    img_addr_gen #(
        .WIN_X  (WIN_X),
        .WIN_Y  (WIN_Y),
        .WIN_W  (WIN_W),
        .WIN_H  (WIN_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .pix_en    (pix_en),
        .x         (x),
        .y         (y),
        .vga_fetch (vga_fetch),
        .vga_addr  (vga_addr)
    );

`ifdef IMG_ARB_VBLANK_WR_EN
    logic [9:0] y_last;
    logic [9:0] y_cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            y_last <= '0;
        end else if (pix_en) begin
            y_last <= y;
        end
    end

    // Use the live row on a pixel tick so the grant lands on that tick.
    assign y_cur = pix_en ? y : y_last;
    assign wr_ok = y_cur >= 10'(V_ACTIVE);
`else
    assign wr_ok = 1'b1;
`endif

    always_comb begin
        gnt       = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        owner_d   = OWN_NONE;
        if (rst) begin
            owner_d = OWN_NONE;
        end else if (vga_fetch) begin
            mem_addr = vga_addr;
            owner_d  = OWN_VGA;
        end else if (cpu.cpu_req && (!cpu.cpu_we || wr_ok)) begin
            gnt       = 1'b1;
            mem_addr  = cpu.cpu_addr;
            mem_we    = cpu.cpu_we;
            mem_wdata = cpu.cpu_wdata;
            owner_d   = cpu.cpu_we ? OWN_NONE : OWN_CPU;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q  <= OWN_NONE;
            miss_q   <= 1'b0;
            pix_data <= '0;
            pix_hit  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            owner_q  <= owner_d;
            miss_q   <= pix_en && !vga_fetch;
            rvalid_q <= owner_q == OWN_CPU;
            if (owner_q == OWN_CPU) begin
                rdata_q <= mem_rdata;
            end
            if (owner_q == OWN_VGA) begin
                pix_data <= mem_rdata;
                pix_hit  <= 1'b1;
            end else if (miss_q) begin
                pix_hit <= 1'b0;
            end
        end
    end

    assign cpu.cpu_gnt    = gnt;
    assign cpu.cpu_rvalid = rvalid_q;
    assign cpu.cpu_rdata  = rdata_q;

endmodule

// File: tb/tb_image_mem_arbiter.sv
// Directed bench for image_mem_arbiter with a behavioural sync RAM.
// Honors IMG_ARB_VBLANK_WR_EN when defined.
module tb_image_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fill = 1'b1;
    logic        pix_en = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic [7:0]  pix_data;
    logic        pix_hit;
    logic [13:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic [7:0]  ram [0:16383];

    int checks   = 0;
    int failures = 0;
    int rv_cnt   = 0;
    logic [7:0] rv_data = '0;

    image_mem_arbiter_if #(.ADDR_W(14), .DATA_W(8)) cpu ();

    image_mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .pix_en    (pix_en),
        .x         (x),
        .y         (y),
        .pix_data  (pix_data),
        .pix_hit   (pix_hit),
        .cpu       (cpu.slave),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int a);
        logic [31:0] v;
        v = a;
        return v[7:0] ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 16384; i++) ram[i] <= pat(i);
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    always @(negedge clk) begin
        if (cpu.cpu_rvalid) begin
            rv_cnt  = rv_cnt + 1;
            rv_data = cpu.cpu_rdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_issue(input logic we, input logic [13:0] a,
                             input logic [7:0] d, input int max_wait,
                             output int waited);
        cpu.cpu_req   = 1'b1;
        cpu.cpu_we    = we;
        cpu.cpu_addr  = a;
        cpu.cpu_wdata = d;
        waited = -1;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            if (cpu.cpu_gnt) begin
                waited = i;
                break;
            end
            step();
        end
        step();
        cpu.cpu_req = 1'b0;
        cpu.cpu_we  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int w;
        int base;
        cpu.cpu_req   = 1'b1;
        cpu.cpu_we    = 1'b1;
        cpu.cpu_addr  = 14'd7;
        cpu.cpu_wdata = 8'h11;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_gnt", cpu.cpu_gnt, 0);
            chk("rst_hit", pix_hit, 0);
            chk("rst_we", mem_we, 0);
            step();
        end
        chk("rst_addr", mem_addr, 0);
        fill = 1'b0;
        rst  = 1'b0;
        @(negedge clk);
        chk("rst_pix_data", pix_data, 0);
        chk("rst_rdata", cpu.cpu_rdata, 0);
        chk("rst_rvalid", cpu.cpu_rvalid, 0);
        chk("first_gnt", cpu.cpu_gnt, 1);
        chk("first_we", mem_we, 1);
        chk("first_addr", mem_addr, 7);
        step();
        cpu.cpu_req = 1'b0;
        cpu.cpu_we  = 1'b0;

        base = rv_cnt;
        cpu_issue(1'b1, 14'd42, 8'hA5, 4, w);
        chk("wr_wait", w, 0);
        repeat (3) step();
        chk("wr_no_rvalid", rv_cnt - base, 0);
        cpu_issue(1'b0, 14'd42, 8'h00, 4, w);
        chk("rd_wait", w, 0);
        repeat (3) step();
        chk("rd_rvalid_cnt", rv_cnt - base, 1);
        chk("rd_data42", rv_data, 8'hA5);
        cpu_issue(1'b0, 14'd7, 8'h00, 4, w);
        repeat (3) step();
        chk("rd_data7", rv_data, 8'h11);

        pix_en = 1'b1;
        x = 10'd5;
        y = 10'd0;
        cpu.cpu_req  = 1'b1;
        cpu.cpu_we   = 1'b0;
        cpu.cpu_addr = 14'h1234;
        @(negedge clk);
        chk("col_addr", mem_addr, 5);
        chk("col_gnt0", cpu.cpu_gnt, 0);
        step();
        pix_en = 1'b0;
        @(negedge clk);
        chk("col_gnt1", cpu.cpu_gnt, 1);
        chk("col_cpu_addr", mem_addr, 14'h1234);
        step();
        cpu.cpu_req = 1'b0;
        @(negedge clk);
        chk("col_rvalid_early", cpu.cpu_rvalid, 0);
        step();
        @(negedge clk);
        chk("col_rvalid", cpu.cpu_rvalid, 1);
        chk("col_rdata", cpu.cpu_rdata, 8'h6E);
        chk("col_pix_data", pix_data, 8'h5F);
        chk("col_pix_hit", pix_hit, 1);
        step();

        for (int r = 0; r < 100; r++) begin
            for (int c = 0; c <= 100; c++) begin
                pix_en = 1'b1;
                x = 10'(c);
                y = 10'(r);
                @(negedge clk);
                if (r == 0 && c == 0)   chk("a_0_0", mem_addr, 0);
                if (r == 0 && c == 99)  chk("a_99_0", mem_addr, 99);
                if (r == 1 && c == 0)   chk("a_0_1", mem_addr, 100);
                if (r == 50 && c == 50) chk("a_50_50", mem_addr, 5050);
                if (r == 99 && c == 99) chk("a_99_99", mem_addr, 9999);
                if (r == 0 && c == 100) begin
                    chk("hit_99_0", pix_hit, 1);
                    chk("data_99_0", pix_data, 8'h39);
                end
                if (r == 1 && c == 0) begin
                    chk("miss_hit", pix_hit, 0);
                    chk("miss_hold", pix_data, 8'h39);
                end
                step();
                pix_en = 1'b0;
                step();
            end
        end
        pix_en = 1'b1;
        x = 10'd0;
        y = 10'd100;
        step();
        pix_en = 1'b0;
        step();
        pix_en = 1'b1;
        x = 10'd3;
        y = 10'd0;
        @(negedge clk);
        chk("rowbase_clr", mem_addr, 3);
        step();
        pix_en = 1'b0;
        step();

        base = rv_cnt;
        cpu.cpu_req  = 1'b1;
        cpu.cpu_we   = 1'b0;
        cpu.cpu_addr = 14'd42;
        @(negedge clk);
        chk("mid_gnt", cpu.cpu_gnt, 1);
        step();
        cpu.cpu_req = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (4) step();
        chk("mid_no_rvalid", rv_cnt - base, 0);
        chk("mid_hit", pix_hit, 0);

        pix_en = 1'b1;
        x = 10'd200;
        y = 10'd10;
        step();
        pix_en = 1'b0;
`ifdef IMG_ARB_VBLANK_WR_EN
        cpu.cpu_req   = 1'b1;
        cpu.cpu_we    = 1'b1;
        cpu.cpu_addr  = 14'd300;
        cpu.cpu_wdata = 8'h5C;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("vb_stall", cpu.cpu_gnt, 0);
            step();
        end
        pix_en = 1'b1;
        x = 10'd0;
        y = 10'd480;
        @(negedge clk);
        chk("vb_gnt", cpu.cpu_gnt, 1);
        chk("vb_we", mem_we, 1);
        step();
        pix_en = 1'b0;
        cpu.cpu_req = 1'b0;
        cpu.cpu_we  = 1'b0;
        pix_en = 1'b1;
        x = 10'd200;
        y = 10'd10;
        step();
        pix_en = 1'b0;
        cpu_issue(1'b0, 14'd300, 8'h00, 4, w);
        chk("vb_rd_wait", w, 0);
`else
        cpu_issue(1'b1, 14'd300, 8'h5C, 4, w);
        chk("any_wr_wait", w, 0);
        cpu_issue(1'b0, 14'd300, 8'h00, 4, w);
        chk("any_rd_wait", w, 0);
`endif
        repeat (3) step();
        chk("wr300_data", rv_data, 8'h5C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
